// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: word RAM with fixed wait states, pipeline
// stall/done handshake, a memory-mapped LED register and a sticky error flag.
module data_mem_responder #(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] LED_ADDR    = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [31:0] MemWriteData_mem,
  output logic [31:0] MemDout,
  output logic        Mem_Stall,
  output logic        Mem_Done,
  output logic [7:0]  LED,
  output logic        Mem_Err,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LP_WC_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rd;
  logic        r_wr;
  logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];

  logic                  w_req;
  logic                  w_commit;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_load;
  logic                  w_is_led;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign w_req = MemRead_mem | MemWrite_mem;

  // With zero wait states the access completes straight out of IDLE, so the
  // live inputs are used; otherwise the values latched at acceptance are.
  assign w_addr   = (r_state == S_IDLE) ? ALUResult_mem    : r_addr;
  assign w_wdata  = (r_state == S_IDLE) ? MemWriteData_mem : r_wdata;
  assign w_rd     = (r_state == S_IDLE) ? MemRead_mem      : r_rd;
  assign w_wr     = (r_state == S_IDLE) ? MemWrite_mem     : r_wr;
  assign w_load   = w_rd & ~w_wr;
  assign w_is_led = (w_addr[31:2] == LED_ADDR[31:2]);
  assign w_err    = (w_addr[1:0] != 2'b00) | (w_rd & w_wr);
  assign w_idx    = w_addr[ADDR_WIDTH+1:2];

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_commit   = 1'b0;
    Mem_Stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          Mem_Stall = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next   = S_DONE;
            w_commit = 1'b1;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = LP_WC_LOAD;
          end
        end
      end
      S_WAIT: begin
        Mem_Stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_next   = S_DONE;
          w_commit = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (rst) begin
      Mem_Stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      MemDout <= 32'd0;
      LED     <= 8'd0;
      Mem_Err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= ALUResult_mem;
        r_wdata <= MemWriteData_mem;
        r_rd    <= MemRead_mem;
        r_wr    <= MemWrite_mem;
      end
      if (w_commit) begin
        if (w_wr && w_is_led) begin
          LED <= w_wdata[7:0];
        end
        if (w_load) begin
          MemDout <= w_is_led ? {24'd0, LED} : r_mem[w_idx];
        end
        if (w_err) begin
          Mem_Err <= 1'b1;
        end
      end
    end
  end

  // RAM contents survive reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_wr && !w_is_led) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  assign Mem_Done    = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule
